// File: rtl/bus_poll_pkg.sv
// bus_poll_pkg: shared states, widths and error codes for the sensor bus poller
package bus_poll_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RX, GAP} state_t;
  localparam int SENSOR_W = 3;
  localparam int DATAREAD_W = 11;
  localparam logic [7:0] ERR_CRC = 8'hC0;
  localparam logic [7:0] ERR_TIMEOUT = 8'hA0;
  localparam logic [7:0] ERR_COLLISION = 8'hE0;
  function automatic logic [DATAREAD_W-1:0] err_word(input logic [7:0] code, input logic [SENSOR_W-1:0] s);
    return {{SENSOR_W{1'b0}}, code | {{(8-SENSOR_W){1'b0}}, s}};
  endfunction
endpackage

// File: rtl/poll_timer.sv
// poll_timer: clearable up-counter flagging when it equals the supplied limit
module poll_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         terminal
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign terminal = cnt_q == limit;
endmodule

// File: rtl/bus_poll_scheduler.sv
// bus_poll_scheduler: round-robin sensor poller with timeout/collision reporting; BUS_POLL_RETRY_EN adds retries
module bus_poll_scheduler
  import bus_poll_pkg::*;
#(
  parameter int NUM_SENSORS = 7,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int GAP_CYCLES = 1000,
  parameter int MAX_RETRIES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           rx_data,
  input  logic                  rx_done,
  input  logic                  crc_ok,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic [7:0]            tx_byte,
  output logic                  tx_start,
  output logic [DATAREAD_W-1:0] dataread,
  output logic                  dataread_valid,
  output logic                  busy
);
  localparam int TW = $clog2((TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES) + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LIM = TW'(GAP_CYCLES - 1);
  localparam logic [SENSOR_W-1:0] LAST = SENSOR_W'(NUM_SENSORS);
  state_t state_q, state_d;
  logic [SENSOR_W-1:0] sensor_q, sensor_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic tx_start_q, tx_start_d;
  logic [DATAREAD_W-1:0] dataread_q, dataread_d;
  logic valid_q, valid_d;
  logic timer_end, fault, can_retry;
  logic [7:0] fault_code;
  logic unused_chk;
  assign unused_chk = ^rx_data[7:0];
`ifdef BUS_POLL_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retry_q, retry_d;
  assign can_retry = retry_q < RW'(MAX_RETRIES);
`else
  logic unused_cfg;
  assign unused_cfg = MAX_RETRIES != 0;
  assign can_retry = 1'b0;
`endif
  poll_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_d != state_q),
    .limit    (state_q == WAIT_RX ? TO_LIM : GAP_LIM),
    .terminal (timer_end)
  );
  always_comb begin
    state_d = state_q;
    sensor_d = sensor_q;
    tx_byte_d = tx_byte_q;
    tx_start_d = 1'b0;
    dataread_d = dataread_q;
    valid_d = 1'b0;
    fault = 1'b0;
    fault_code = rx_done ? ERR_CRC : ERR_TIMEOUT;
`ifdef BUS_POLL_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: state_d = enable ? SEND : IDLE;
      SEND: if (!tx_active) begin
        tx_start_d = 1'b1;
        tx_byte_d = {{(8-SENSOR_W){1'b0}}, sensor_q};
        state_d = WAIT_TX;
      end
      WAIT_TX: state_d = tx_done ? WAIT_RX : WAIT_TX;
      WAIT_RX: if (rx_done && crc_ok) begin
        dataread_d = {sensor_q, rx_data[15:8]};
        valid_d = 1'b1;
        state_d = GAP;
      end else fault = rx_done || timer_end;
      GAP: if (timer_end) begin
        sensor_d = sensor_q == LAST ? SENSOR_W'(1) : sensor_q + 1'b1;
        state_d = enable ? SEND : IDLE;
`ifdef BUS_POLL_RETRY_EN
        retry_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fault && can_retry) begin
      state_d = SEND;
`ifdef BUS_POLL_RETRY_EN
      retry_d = retry_q + 1'b1;
`endif
    end else if (fault) begin
      dataread_d = err_word(fault_code, sensor_q);
      valid_d = 1'b1;
      state_d = GAP;
    end
    if (rx_done && (state_q == SEND || state_q == WAIT_TX || state_q == GAP)) begin
      dataread_d = err_word(ERR_COLLISION, sensor_q);
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sensor_q <= SENSOR_W'(1);
      tx_byte_q <= 8'h01;
      tx_start_q <= 1'b0;
      dataread_q <= '0;
      valid_q <= 1'b0;
`ifdef BUS_POLL_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sensor_q <= sensor_d;
      tx_byte_q <= tx_byte_d;
      tx_start_q <= tx_start_d;
      dataread_q <= dataread_d;
      valid_q <= valid_d;
`ifdef BUS_POLL_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end
  assign tx_byte = tx_byte_q;
  assign tx_start = tx_start_q;
  assign dataread = dataread_q;
  assign dataread_valid = valid_q;
  assign busy = state_q != IDLE;
endmodule
